// File: rtl/cam_pkg.sv
// Shared encodings for the block-RAM CAM: command opcodes, response status
// codes and controller state encodings.
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_OP_INSERT      = 2'd0,
    CAM_OP_DELETE_KEY  = 2'd1,
    CAM_OP_DELETE_ADDR = 2'd2,
    CAM_OP_NOP         = 2'd3
  } cam_op_e;

  typedef enum logic [1:0] {
    CAM_ST_OK       = 2'd0,
    CAM_ST_EXISTS   = 2'd1,
    CAM_ST_FULL     = 2'd2,
    CAM_ST_NOTFOUND = 2'd3
  } cam_status_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_KEY_RD,
    ST_KEY_CHK,
    ST_ADDR_RD,
    ST_WR,
    ST_RSP
  } cam_state_e;

endpackage

// File: rtl/cam_bram_alloc_if.sv
// Command, response, lookup and status signals of the allocating CAM.
// The master side issues commands and lookups; the slave side is the CAM.
interface cam_bram_alloc_if #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 5
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_key;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  rsp_valid;
  logic [1:0]            rsp_status;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  lookup_valid;
  logic [DATA_WIDTH-1:0] lookup_key;
  logic                  result_valid;
  logic                  result_match;
  logic [ADDR_WIDTH-1:0] result_addr;
  logic [ADDR_WIDTH:0]   used_count;
  logic                  init_busy;

  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_addr, lookup_valid, lookup_key,
    input  cmd_ready, rsp_valid, rsp_status, rsp_addr,
           result_valid, result_match, result_addr, used_count, init_busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, cmd_addr, lookup_valid, lookup_key,
    output cmd_ready, rsp_valid, rsp_status, rsp_addr,
           result_valid, result_match, result_addr, used_count, init_busy
  );
endinterface

// File: rtl/cam_slice_ram.sv
// One CAM slice: true dual-port RAM of match vectors. Port A is a read-only
// compare port; port B performs read-modify-write (read first, then write).
module cam_slice_ram #(
  parameter int ADDR_W = 9,
  parameter int VEC_W  = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [VEC_W-1:0]  a_dout,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_rd,
  input  logic              b_we,
  input  logic              b_zero,
  input  logic [VEC_W-1:0]  b_set,
  input  logic [VEC_W-1:0]  b_clr,
  output logic [VEC_W-1:0]  b_dout
);
  logic [VEC_W-1:0] mem [1 << ADDR_W];

  // Read-first on both ports: a same-cycle compare sees the old vector.
  always_ff @(posedge clk) begin
    a_dout <= mem[a_addr];
    if (b_rd) b_dout <= mem[b_addr];
    if (b_we) mem[b_addr] <= b_zero ? '0 : ((b_dout & ~b_clr) | b_set);
  end
endmodule

// File: rtl/priority_encoder.sv
// Returns the index of the lowest set bit of vec (LSB has priority) and
// whether any bit is set.
module priority_encoder #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign any = |vec;
endmodule

// File: rtl/cam_bram_alloc.sv
// Sliced block-RAM binary CAM with self-managed slot allocation: command FSM
// on RAM port B, fully pipelined two-cycle lookup on RAM port A.
import cam_pkg::*;

module cam_bram_alloc #(
  parameter int DATA_WIDTH  = 48,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  cam_bram_alloc_if.slave bus
);
  localparam int ENTRIES     = 1 << ADDR_WIDTH;
  localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

  cam_state_e            state;
  logic [SLICE_WIDTH-1:0] init_cnt;
  cam_op_e               cur_op;
  logic [DATA_WIDTH-1:0] cur_key;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ENTRIES-1:0]    set_vec, clr_vec, bitmap;
  logic [ADDR_WIDTH:0]   used_count;
  logic                  rsp_valid;
  cam_status_e           rsp_status;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [DATA_WIDTH-1:0] key_mem [ENTRIES];

  logic [ENTRIES-1:0]    a_dout [SLICE_COUNT];
  logic [ENTRIES-1:0]    b_dout [SLICE_COUNT];
  logic [ENTRIES-1:0]    lk_vec, ck_vec;
  logic [ADDR_WIDTH-1:0] lk_idx, hit_idx, free_idx;
  logic                  lk_any, hit_any, free_any;
  logic                  init_st, b_rd, b_we, alloc;
  logic                  vld_p0, vld_p1, match_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  function automatic logic [ENTRIES-1:0] onehot(input logic [ADDR_WIDTH-1:0] i);
    return ENTRIES'(1) << i;
  endfunction

  assign init_st = (state == ST_INIT);
  assign b_rd    = (state == ST_KEY_RD);
  assign b_we    = init_st || (state == ST_WR);

  // The last slice only decodes the key bits that actually exist.
  for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
    localparam int SW = (s == SLICE_COUNT - 1) ? DATA_WIDTH - s * SLICE_WIDTH : SLICE_WIDTH;
    logic [SW-1:0] b_addr;
    assign b_addr = init_st ? init_cnt[SW-1:0] : cur_key[s*SLICE_WIDTH +: SW];
    cam_slice_ram #(.ADDR_W(SW), .VEC_W(ENTRIES)) u_ram (
      .clk    (clk),
      .a_addr (bus.lookup_key[s*SLICE_WIDTH +: SW]),
      .a_dout (a_dout[s]),
      .b_addr (b_addr),
      .b_rd   (b_rd),
      .b_we   (b_we),
      .b_zero (init_st),
      .b_set  (set_vec),
      .b_clr  (clr_vec),
      .b_dout (b_dout[s])
    );
  end

  always_comb begin
    lk_vec = '1;
    ck_vec = '1;
    for (int s = 0; s < SLICE_COUNT; s++) begin
      lk_vec &= a_dout[s];
      ck_vec &= b_dout[s];
    end
  end

  priority_encoder #(.WIDTH(ENTRIES), .IDX_W(ADDR_WIDTH)) u_lk_enc (
    .vec(lk_vec), .idx(lk_idx), .any(lk_any));
  priority_encoder #(.WIDTH(ENTRIES), .IDX_W(ADDR_WIDTH)) u_hit_enc (
    .vec(ck_vec), .idx(hit_idx), .any(hit_any));
  priority_encoder #(.WIDTH(ENTRIES), .IDX_W(ADDR_WIDTH)) u_free_enc (
    .vec(~bitmap), .idx(free_idx), .any(free_any));

  assign alloc = rst_n && (state == ST_KEY_CHK) && (cur_op == CAM_OP_INSERT) && !hit_any && free_any;

  always_ff @(posedge clk) begin
    if (alloc) key_mem[free_idx] <= cur_key;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      init_cnt   <= '1;
      bitmap     <= '0;
      used_count <= '0;
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_INIT: begin
          init_cnt <= init_cnt - SLICE_WIDTH'(1);
          if (init_cnt == '0) state <= ST_IDLE;
        end
        ST_IDLE: if (bus.cmd_valid) begin
          cur_op   <= cam_op_e'(bus.cmd_op);
          cur_key  <= bus.cmd_key;
          cur_addr <= bus.cmd_addr;
          unique case (cam_op_e'(bus.cmd_op))
            CAM_OP_INSERT, CAM_OP_DELETE_KEY: state <= ST_KEY_RD;
            CAM_OP_DELETE_ADDR:               state <= ST_ADDR_RD;
            default: begin
              rsp_status <= CAM_ST_OK;
              rsp_addr   <= '0;
              rsp_valid  <= 1'b1;
              state      <= ST_RSP;
            end
          endcase
        end
        ST_ADDR_RD: begin
          if (!bitmap[cur_addr]) begin
            rsp_status <= CAM_ST_NOTFOUND;
            rsp_addr   <= cur_addr;
            rsp_valid  <= 1'b1;
            state      <= ST_RSP;
          end else begin
            cur_key <= key_mem[cur_addr];
            state   <= ST_KEY_RD;
          end
        end
        ST_KEY_RD: state <= ST_KEY_CHK;
        ST_KEY_CHK: begin
          set_vec <= '0;
          clr_vec <= '0;
          if (cur_op == CAM_OP_INSERT) begin
            if (hit_any || !free_any) begin
              rsp_status <= hit_any ? CAM_ST_EXISTS : CAM_ST_FULL;
              rsp_addr   <= hit_any ? hit_idx : '0;
              rsp_valid  <= 1'b1;
              state      <= ST_RSP;
            end else begin
              bitmap[free_idx] <= 1'b1;
              set_vec    <= onehot(free_idx);
              cur_addr   <= free_idx;
              rsp_status <= CAM_ST_OK;
              rsp_addr   <= free_idx;
              state      <= ST_WR;
            end
          end else if (cur_op == CAM_OP_DELETE_KEY && !hit_any) begin
            rsp_status <= CAM_ST_NOTFOUND;
            rsp_addr   <= '0;
            rsp_valid  <= 1'b1;
            state      <= ST_RSP;
          end else begin
            // DELETE_ADDR already knows its index; DELETE_KEY takes the hit.
            clr_vec    <= onehot((cur_op == CAM_OP_DELETE_KEY) ? hit_idx : cur_addr);
            cur_addr   <= (cur_op == CAM_OP_DELETE_KEY) ? hit_idx : cur_addr;
            rsp_status <= CAM_ST_OK;
            rsp_addr   <= (cur_op == CAM_OP_DELETE_KEY) ? hit_idx : cur_addr;
            state      <= ST_WR;
          end
        end
        ST_WR: begin
          if (cur_op == CAM_OP_INSERT) begin
            used_count <= used_count + (ADDR_WIDTH + 1)'(1);
          end else begin
            used_count       <= used_count - (ADDR_WIDTH + 1)'(1);
            bitmap[cur_addr] <= 1'b0;
          end
          rsp_valid <= 1'b1;
          state     <= ST_RSP;
        end
        ST_RSP:  state <= ST_IDLE;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Lookup stage p0: slice RAMs registered; stage p1: AND + encode registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      match_p1 <= 1'b0;
      addr_p1  <= '0;
    end else begin
      vld_p0   <= bus.lookup_valid && !init_st;
      vld_p1   <= vld_p0;
      match_p1 <= vld_p0 && lk_any;
      addr_p1  <= (vld_p0 && lk_any) ? lk_idx : '0;
    end
  end

  assign bus.cmd_ready    = (state == ST_IDLE);
  assign bus.init_busy    = init_st;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_status   = rsp_status;
  assign bus.rsp_addr     = rsp_addr;
  assign bus.used_count   = used_count;
  assign bus.result_valid = vld_p1;
  assign bus.result_match = match_p1;
  assign bus.result_addr  = addr_p1;
endmodule

// File: tb/tb_cam_bram_alloc.sv
// Directed and randomized bench for cam_bram_alloc against a table-level
// reference model of the CAM contents and the command latencies.
module tb_cam_bram_alloc;
  import cam_pkg::*;

  localparam int DW = 48;
  localparam int AW = 5;
  localparam int SW = 9;
  localparam int N  = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_bram_alloc_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cam_bram_alloc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mk [N];
  bit            mu [N];
  logic [DW-1:0] pool [8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rkey();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic int model_used();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mu[i]);
    return c;
  endfunction

  function automatic int model_find(input logic [DW-1:0] key);
    for (int i = 0; i < N; i++) if (mu[i] && mk[i] == key) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) mu[i] = 1'b0;
  endfunction

  // Expected status/address/latency of one command, updating the table.
  task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] key, input logic [AW-1:0] addr,
                           output logic [1:0] st, output logic [AW-1:0] ra, output int lat);
    int hit, fr;
    hit = model_find(key);
    fr  = -1;
    for (int i = N - 1; i >= 0; i--) if (!mu[i]) fr = i;
    case (op)
      2'd0: begin
        if (hit >= 0)    begin st = CAM_ST_EXISTS; ra = AW'(hit); lat = 3; end
        else if (fr < 0) begin st = CAM_ST_FULL;   ra = '0;       lat = 3; end
        else begin
          mu[fr] = 1'b1; mk[fr] = key;
          st = CAM_ST_OK; ra = AW'(fr); lat = 4;
        end
      end
      2'd1: begin
        if (hit >= 0) begin mu[hit] = 1'b0; st = CAM_ST_OK; ra = AW'(hit); lat = 4; end
        else          begin st = CAM_ST_NOTFOUND; ra = '0; lat = 3; end
      end
      2'd2: begin
        if (mu[addr]) begin mu[addr] = 1'b0; st = CAM_ST_OK; lat = 5; end
        else          begin st = CAM_ST_NOTFOUND; lat = 2; end
        ra = addr;
      end
      default: begin st = CAM_ST_OK; ra = '0; lat = 0; end
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] key, input logic [AW-1:0] addr,
                         output logic [1:0] st, output logic [AW-1:0] ra, output int lat);
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    bus.cmd_addr  = addr;
    w = 0;
    while (!bus.cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check("cmd_accept", 64'(bus.cmd_ready), 64'(1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_seen", 64'(bus.rsp_valid), 64'(1));
    st = bus.rsp_status;
    ra = bus.rsp_addr;
    @(negedge clk);
    check("rsp_pulse", 64'(bus.rsp_valid), 64'(0));
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] key, input logic [AW-1:0] addr,
                        input string tag);
    logic [1:0]    es, st;
    logic [AW-1:0] ea, ra;
    int            el, lat;
    model_cmd(op, key, addr, es, ea, el);
    run_cmd(op, key, addr, st, ra, lat);
    check({tag, "_status"}, 64'(st), 64'(es));
    check({tag, "_addr"}, 64'(ra), 64'(ea));
    if (el > 0) check({tag, "_latency"}, 64'(lat), 64'(el));
    check({tag, "_used"}, 64'(bus.used_count), 64'(model_used()));
  endtask

  task automatic lookup_chk(input logic [DW-1:0] key, input string tag);
    int idx;
    @(negedge clk);
    bus.lookup_valid = 1'b1;
    bus.lookup_key   = key;
    @(negedge clk);
    bus.lookup_valid = 1'b0;
    @(negedge clk);
    idx = model_find(key);
    check({tag, "_valid"}, 64'(bus.result_valid), 64'(1));
    check({tag, "_match"}, 64'(bus.result_match), 64'(idx >= 0));
    if (idx >= 0) check({tag, "_addr"}, 64'(bus.result_addr), 64'(idx));
  endtask

  task automatic do_reset();
    int n;
    bit rdy;
    @(negedge clk);
    rst_n = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.lookup_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_busy", 64'(bus.init_busy), 64'(1));
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_result_valid", 64'(bus.result_valid), 64'(0));
    check("rst_used", 64'(bus.used_count), 64'(0));
    rst_n = 1'b1;
    n   = 0;
    rdy = 1'b0;
    while (bus.init_busy && n < 2000) begin
      rdy |= bus.cmd_ready;
      n++;
      @(negedge clk);
    end
    check("init_cycles", 64'(n), 64'(1 << SW));
    check("init_ready_low", 64'(rdy), 64'(0));
    check("idle_ready", 64'(bus.cmd_ready), 64'(1));
    check("idle_used", 64'(bus.used_count), 64'(0));
    model_clear();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    es;
    logic [AW-1:0] ea;
    int            el, rsp_cyc, guard;
    logic [DW-1:0] nk, rk;
    bit            saw_rsp;

    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = '0;
    bus.cmd_key      = '0;
    bus.cmd_addr     = '0;
    bus.lookup_valid = 1'b0;
    bus.lookup_key   = '0;
    model_clear();
    for (int i = 0; i < 8; i++) pool[i] = rkey();

    do_reset();

    do_cmd(2'd0, 48'h0011_2233_4455, '0, "ins_first");
    lookup_chk(48'h0011_2233_4455, "lk_first");
    lookup_chk(48'h0011_2233_4456, "lk_neighbour");
    do_cmd(2'd0, 48'h0011_2233_4455, '0, "ins_dup");

    guard = 0;
    while (model_used() < N && guard < 100) begin
      do_cmd(2'd0, rkey(), '0, "ins_fill");
      guard++;
    end
    do_cmd(2'd0, rkey(), '0, "ins_full");
    for (int i = 0; i < 6; i++) lookup_chk(mk[$urandom_range(0, N - 1)], "lk_full_hit");
    lookup_chk(rkey(), "lk_full_miss");

    do_cmd(2'd2, '0, AW'(7), "del_addr7");
    do_cmd(2'd0, rkey(), '0, "ins_reuse7");
    do_cmd(2'd1, 48'hDEAD_0000_BEEF, '0, "del_key_absent");
    do_cmd(2'd2, '0, AW'(12), "del_addr12");
    do_cmd(2'd2, '0, AW'(12), "del_addr12_free");
    do_cmd(2'd3, '0, '0, "nop");

    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom_range(0, 2)), pool[$urandom_range(0, 7)], AW'($urandom_range(0, N - 1)), "mix");
      lookup_chk(pool[$urandom_range(0, 7)], "lk_mix");
    end

    // Lookups every cycle while an INSERT of nk is in flight.
    if (model_used() == N) do_cmd(2'd2, '0, AW'(3), "make_room");
    nk = rkey();
    model_cmd(2'd0, nk, '0, es, ea, el);
    rsp_cyc = -1;
    @(negedge clk);
    check("bb_ready", 64'(bus.cmd_ready), 64'(1));
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = 2'd0;
    bus.cmd_key      = nk;
    bus.lookup_valid = 1'b1;
    bus.lookup_key   = nk;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.cmd_valid    = 1'b0;
      bus.lookup_valid = (c < 8);
      if (bus.rsp_valid) rsp_cyc = c;
      if (c >= 2) begin
        check("bb_valid", 64'(bus.result_valid), 64'(1));
        check("bb_match", 64'(bus.result_match), 64'((c - 2) > (el - 1)));
        if ((c - 2) > (el - 1)) check("bb_addr", 64'(bus.result_addr), 64'(ea));
      end
    end
    bus.lookup_valid = 1'b0;
    check("bb_rsp_cycle", 64'(rsp_cyc), 64'(el));
    check("bb_used", 64'(bus.used_count), 64'(model_used()));

    // Reset while an INSERT sits in KEY_CHK.
    if (model_used() == N) do_cmd(2'd2, '0, AW'(5), "make_room2");
    rk = rkey();
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    bus.cmd_key   = rk;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n   = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      saw_rsp |= bus.rsp_valid;
    end
    check("abort_no_rsp", 64'(saw_rsp), 64'(0));
    do_reset();
    lookup_chk(rk, "lk_after_abort");
    lookup_chk(48'h0011_2233_4455, "lk_after_reset");
    do_cmd(2'd0, rk, '0, "ins_after_reset");
    lookup_chk(rk, "lk_after_reinsert");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
